// File: rtl/dvfs_multi_proc_freq_assigner.sv
// rtl/dvfs_multi_proc_freq_assigner.sv - per-task lowest-energy DVFS level picker with per-processor finish times
module dvfs_multi_proc_freq_assigner #(
   parameter int N_TASKS  = 10,
   parameter int L_LEVELS = 8,
   parameter int NUM_PROC = 3,
   parameter int DW       = 32,
   parameter int FRAC     = 16,
   parameter int PW       = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1,
   parameter int LW       = (L_LEVELS > 1) ? $clog2(L_LEVELS) : 1,
   parameter int IW       = (N_TASKS  > 1) ? $clog2(N_TASKS)  : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [N_TASKS*DW-1:0]        cycles,
   input  logic [N_TASKS*L_LEVELS*DW-1:0] inv_rate,
   input  logic [L_LEVELS*DW-1:0]       power,
   input  logic [N_TASKS*DW-1:0]        deadline,
   input  logic [N_TASKS*PW-1:0]        proc_id,
   input  logic [DW-1:0]                energy_budget,
   output logic                         busy,
   output logic                         done,
   output logic                         valid,
   output logic [IW-1:0]                fail_task,
   output logic [N_TASKS*LW-1:0]        assigned_level,
   output logic [DW-1:0]                e_total,
   output logic [NUM_PROC*DW-1:0]       t_proc
);

   typedef enum logic [2:0] {
      IDLE, LOAD, CALC_T, CALC_E, CHECK, COMMIT, DONE
   } state_t;

   localparam logic [LW-1:0] LAST_LEVEL = LW'(L_LEVELS - 1);
   localparam logic [IW-1:0] LAST_TASK  = IW'(N_TASKS - 1);
   localparam logic [PW:0]   NPROC_EXT  = (PW + 1)'(NUM_PROC);

   state_t          state, next_state;
   logic [IW-1:0]   ti;
   logic [LW-1:0]   li;
   logic [PW-1:0]   pi;
   logic [DW-1:0]   budget_r;
   logic [DW-1:0]   t_r, e_r;
   logic [DW-1:0]   best_e, best_t;
   logic [LW-1:0]   best_l;
   logic            found;

   // Fixed-point multiply; anything that does not fit in DW bits clamps to all-ones
   function automatic logic [DW-1:0] fpmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [2*DW-1:0] prod;
      prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      if (|prod[2*DW-1:DW+FRAC])
         return '1;
      else
         return prod[DW+FRAC-1:FRAC];
   endfunction

   logic [DW-1:0] cyc_i, inv_il, pow_l, dl_i, tp_cur;
   logic [PW-1:0] pid_raw, pid_map;
   logic [DW:0]   sum_t, sum_e;
   logic          feasible;

   // Operand selection and the feasibility test, evaluated with a carry bit so overflow never passes
   always_comb begin
      cyc_i    = cycles[int'(ti)*DW +: DW];
      inv_il   = inv_rate[(int'(ti)*L_LEVELS + int'(li))*DW +: DW];
      pow_l    = power[int'(li)*DW +: DW];
      dl_i     = deadline[int'(ti)*DW +: DW];
      pid_raw  = proc_id[int'(ti)*PW +: PW];
      pid_map  = ({1'b0, pid_raw} >= NPROC_EXT) ? '0 : pid_raw;
      tp_cur   = t_proc[int'(pi)*DW +: DW];
      sum_t    = {1'b0, tp_cur} + {1'b0, t_r};
      sum_e    = {1'b0, e_total} + {1'b0, e_r};
      feasible = (sum_t <= {1'b0, dl_i}) && (sum_e <= {1'b0, budget_r});
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state: three arithmetic steps per level, one commit per task
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = LOAD;
         LOAD:    next_state = CALC_T;
         CALC_T:  next_state = CALC_E;
         CALC_E:  next_state = CHECK;
         CHECK:   next_state = (li == LAST_LEVEL) ? COMMIT : CALC_T;
         COMMIT:  next_state = (!found || ti == LAST_TASK) ? DONE : LOAD;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // Datapath: level scan registers and result accumulators
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ti             <= '0;
         li             <= '0;
         pi             <= '0;
         budget_r       <= '0;
         t_r            <= '0;
         e_r            <= '0;
         best_e         <= '0;
         best_t         <= '0;
         best_l         <= '0;
         found          <= 1'b0;
         valid          <= 1'b0;
         fail_task      <= '0;
         assigned_level <= '0;
         e_total        <= '0;
         t_proc         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  ti             <= '0;
                  budget_r       <= energy_budget;
                  valid          <= 1'b0;
                  fail_task      <= '0;
                  assigned_level <= '0;
                  e_total        <= '0;
                  t_proc         <= '0;
               end
            end
            LOAD: begin
               li     <= '0;
               best_e <= '1;
               found  <= 1'b0;
               pi     <= pid_map;
            end
            CALC_T: t_r <= fpmul(cyc_i, inv_il);
            CALC_E: e_r <= fpmul(t_r, pow_l);
            CHECK: begin
               // Strict compare keeps the lower level on an energy tie
               if (feasible && e_r < best_e) begin
                  best_e <= e_r;
                  best_t <= t_r;
                  best_l <= li;
                  found  <= 1'b1;
               end
               if (li != LAST_LEVEL)
                  li <= li + 1'b1;
            end
            COMMIT: begin
               if (found) begin
                  assigned_level[int'(ti)*LW +: LW] <= best_l;
                  e_total                           <= e_total + best_e;
                  t_proc[int'(pi)*DW +: DW]         <= tp_cur + best_t;
                  if (ti == LAST_TASK)
                     valid <= 1'b1;
                  else
                     ti <= ti + 1'b1;
               end else begin
                  fail_task <= ti;
                  valid     <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dvfs_multi_proc_freq_assigner.sv
// tb/tb_dvfs_multi_proc_freq_assigner.sv - scoreboard bench for dvfs_multi_proc_freq_assigner
module tb_dvfs_multi_proc_freq_assigner;

   localparam int N  = 2;
   localparam int L  = 4;
   localparam int NP = 2;
   localparam int DW = 32;
   localparam int PW = 1;
   localparam int LW = 2;
   localparam int IW = 1;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic [N*DW-1:0]      cycles;
   logic [N*L*DW-1:0]    inv_rate;
   logic [L*DW-1:0]      power;
   logic [N*DW-1:0]      deadline;
   logic [N*PW-1:0]      proc_id;
   logic [DW-1:0]        energy_budget;
   logic                 busy, done, valid;
   logic [IW-1:0]        fail_task;
   logic [N*LW-1:0]      assigned_level;
   logic [DW-1:0]        e_total;
   logic [NP*DW-1:0]     t_proc;

   dvfs_multi_proc_freq_assigner #(
      .N_TASKS(N), .L_LEVELS(L), .NUM_PROC(NP), .DW(DW), .FRAC(16)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .cycles(cycles), .inv_rate(inv_rate),
      .power(power), .deadline(deadline), .proc_id(proc_id), .energy_budget(energy_budget),
      .busy(busy), .done(done), .valid(valid), .fail_task(fail_task),
      .assigned_level(assigned_level), .e_total(e_total), .t_proc(t_proc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [LW-1:0] lv0, lv1;
      logic [DW-1:0] e, t0, t1;
      logic          vld;
      logic [IW-1:0] ft;
      int            lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got === want)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
   endtask

   function automatic logic [DW-1:0] q16(input int v);
      return DW'(v) << 16;
   endfunction

   task automatic set_base(input int d0, input int d1, input int bud, input logic [1:0] pid);
      for (int i = 0; i < N; i++) begin
         cycles[i*DW +: DW] = q16(4);
         for (int l = 0; l < L; l++)
            inv_rate[(i*L+l)*DW +: DW] = 32'h0001_0000 >> l;
      end
      power         = {q16(20), q16(8), q16(3), q16(1)};
      deadline      = {q16(d1), q16(d0)};
      energy_budget = q16(bud);
      proc_id       = pid;
   endtask

   // Drive one start; pop and compare the expected record when done appears
   task automatic run(input exp_t x, input int extra_start, input int budget_poke);
      exp_t w;
      int   cyc;
      bit   seen;
      exp_q.push_back(x);
      @(negedge clk);
      start = 1'b1;
      seen  = 1'b0;
      cyc   = 0;
      while (!seen && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 1) begin
            start = 1'b0;
            check("busy_after_start", busy, 1'b1);
            check("etotal_cleared", e_total, 0);
         end
         if (extra_start > 0 && cyc == extra_start)     start = 1'b1;
         if (extra_start > 0 && cyc == extra_start + 1) start = 1'b0;
         if (budget_poke > 0 && cyc == budget_poke)     energy_budget = q16(100);
         if (done) seen = 1'b1;
      end
      w = exp_q.pop_front();
      check("done_seen", seen, 1'b1);
      check("latency", 64'(cyc), 64'(w.lat));
      check("busy_in_done", busy, 1'b1);
      check("valid", valid, w.vld);
      if (!w.vld) check("fail_task", fail_task, w.ft);
      check("level0", assigned_level[0 +: LW], w.lv0);
      check("level1", assigned_level[LW +: LW], w.lv1);
      check("e_total", e_total, w.e);
      check("t_proc0", t_proc[0 +: DW], w.t0);
      check("t_proc1", t_proc[DW +: DW], w.t1);
      @(posedge clk);
      #1;
      check("done_pulse_1cyc", done, 1'b0);
      check("busy_idle", busy, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("valid_held", valid, w.vld);
   endtask

   exp_t t1, t2, t3, t4, t6;
   int   dn;

   initial begin
      reset = 1'b1;
      start = 1'b0;
      set_base(10, 10, 100, 2'b00);
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_valid", valid, 1'b0);
      check("rst_levels", assigned_level, 0);
      check("rst_etotal", e_total, 0);
      check("rst_tproc", t_proc, 0);
      check("rst_fail", fail_task, 0);
      reset = 1'b0;

      t1 = '{lv0: 0, lv1: 0, e: 32'h80000, t0: 32'h80000, t1: 0, vld: 1, ft: 0, lat: 29};
      t2 = '{lv0: 1, lv1: 0, e: 32'hA0000, t0: 32'h60000, t1: 0, vld: 1, ft: 0, lat: 29};
      t3 = '{lv0: 0, lv1: 0, e: 32'h40000, t0: 32'h40000, t1: 0, vld: 0, ft: 1, lat: 29};
      t4 = '{lv0: 0, lv1: 0, e: 32'h80000, t0: 32'h40000, t1: 32'h40000, vld: 1, ft: 0, lat: 29};
      t6 = '{lv0: 0, lv1: 0, e: 0, t0: 0, t1: 0, vld: 0, ft: 0, lat: 15};

      set_base(10, 10, 100, 2'b00); run(t1, 0, 0);
      set_base(3, 10, 100, 2'b00);  run(t2, 0, 0);
      set_base(10, 10, 7, 2'b00);   run(t3, 0, 3);
      set_base(4, 4, 100, 2'b10);   run(t4, 0, 0);
      set_base(10, 10, 100, 2'b00); run(t1, 5, 0);

      // Mid-run reset: outputs clear, no done pulse follows
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      check("mid_rst_levels", assigned_level, 0);
      check("mid_rst_etotal", e_total, 0);
      @(negedge clk);
      reset = 1'b0;
      dn = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) dn++;
      end
      check("mid_rst_no_done", 64'(dn), 0);
      run(t1, 0, 0);

      for (int i = 0; i < N; i++) begin
         cycles[i*DW +: DW] = 32'hFFFF_0000;
         for (int l = 0; l < L; l++)
            inv_rate[(i*L+l)*DW +: DW] = '1;
      end
      run(t6, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
